// File: rtl/regio_pkg.sv
// regio_pkg: shared types and helpers for the register-I/O arbiter.
// Holds the FSM state enum, length codes, timeout default and slice helper.
package regio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic LEN_BYTE = 1'b0;
    localparam logic LEN_WORD = 1'b1;

    localparam int TMO_DEF = 255;

    // Field i of width w from a packed per-master bus; w must be <= 32.
    function automatic logic [31:0] get_slice(
        input logic [255:0] vec,
        input int           i,
        input int           w
    );
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return 32'(vec >> (i * w)) & mask;
    endfunction

endpackage

// File: rtl/regio_arbiter_if.sv
// regio_m_if: master-side request/ack bus (masters -> arbiter).
// regio_io_if: command/done bus between the arbiter and the register engine.
interface regio_m_if #(
    parameter int NUM_M = 2,
    parameter int OFS_W = 8,
    parameter int DAT_W = 16
);
    logic [NUM_M-1:0]       m_req;
    logic [NUM_M-1:0]       m_wr;
    logic [NUM_M-1:0]       m_len;
    logic [NUM_M*OFS_W-1:0] m_ofs;
    logic [NUM_M*DAT_W-1:0] m_wdata;
    logic [NUM_M-1:0]       m_ack;
    logic                   m_err;
    logic [DAT_W-1:0]       m_rdata;

    modport master (
        output m_req, m_wr, m_len, m_ofs, m_wdata,
        input  m_ack, m_err, m_rdata
    );

    modport slave (
        input  m_req, m_wr, m_len, m_ofs, m_wdata,
        output m_ack, m_err, m_rdata
    );
endinterface

interface regio_io_if #(
    parameter int OFS_W = 8,
    parameter int DAT_W = 16
);
    logic             io_new;
    logic             io_wr;
    logic             io_len;
    logic [OFS_W-1:0] io_ofs;
    logic [DAT_W-1:0] io_wdata;
    logic             io_done;
    logic [DAT_W-1:0] io_rdata;

    modport master (
        output io_new, io_wr, io_len, io_ofs, io_wdata,
        input  io_done, io_rdata
    );

    modport slave (
        input  io_new, io_wr, io_len, io_ofs, io_wdata,
        output io_done, io_rdata
    );
endinterface

// File: rtl/regio_arbiter_rr_pick.sv
// rr_pick: combinational first-one search over req starting at ptr, wrapping.
// Ports: req, ptr in; idx (chosen index), found (any request) out.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        int c;
        c     = 0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/regio_arbiter.sv
// regio_arbiter: round-robin N-master front end for the register I/O engine.
// Ports: clk40m, reset, init_lock, m (master bus), io (engine bus), busy.
module regio_arbiter
    import regio_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int OFS_W   = 8,
    parameter int DAT_W   = 16,
    parameter int TMO_CYC = TMO_DEF
) (
    input  logic        clk40m,
    input  logic        reset,
    input  logic        init_lock,
    regio_m_if.slave    m,
    regio_io_if.master  io,
    output logic        busy
);

    localparam int          IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [15:0] TMO   = 16'(TMO_CYC);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [NUM_M-1:0] elig;
    logic [15:0]      wdog;
    logic             tmo;

    // While init is locked only master 0 may win.
    assign elig = init_lock ? (m.m_req & NUM_M'(1)) : m.m_req;
    assign tmo  = (wdog >= TMO);

    rr_pick #(
        .N     (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (elig),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk40m or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (pick_found) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            // io_done has priority over a coincident timeout
            ST_WAIT:  if (io.io_done || tmo) state_nx = ST_RESP;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk40m or posedge reset) begin
        if (reset) begin
            grant       <= '0;
            rr_ptr      <= '0;
            wdog        <= '0;
            io.io_wr    <= 1'b0;
            io.io_len   <= 1'b0;
            io.io_ofs   <= '0;
            io.io_wdata <= '0;
            m.m_err     <= 1'b0;
            m.m_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant       <= pick_idx;
                        io.io_wr    <= m.m_wr[pick_idx];
                        io.io_len   <= m.m_len[pick_idx];
                        io.io_ofs   <= OFS_W'(get_slice(
                            256'(m.m_ofs), int'(pick_idx), OFS_W));
                        io.io_wdata <= DAT_W'(get_slice(
                            256'(m.m_wdata), int'(pick_idx), DAT_W));
                    end
                end
                ST_ISSUE: begin
                    wdog <= '0;
                end
                ST_WAIT: begin
                    if (io.io_done) begin
                        m.m_rdata <= io.io_rdata;
                        m.m_err   <= 1'b0;
                    end else if (tmo) begin
                        m.m_err <= 1'b1;
                    end else if (wdog != 16'hFFFF) begin
                        wdog <= wdog + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (int'(grant) == NUM_M - 1) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= IDX_W'(int'(grant) + 1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m.m_ack = '0;
        if (state == ST_RESP) m.m_ack[grant] = 1'b1;
    end

    assign io.io_new = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_regio_arbiter.sv
// tb_regio_arbiter: directed table plus corner sequences for regio_arbiter.
// Three masters, timeout of 5 cycles.
module tb_regio_arbiter;

    localparam int NM = 3;

    logic clk40m;
    logic reset;
    logic init_lock;
    logic busy;

    int tests;
    int fails;

    regio_m_if  #(.NUM_M(NM), .OFS_W(8), .DAT_W(16)) mif ();
    regio_io_if #(.OFS_W(8), .DAT_W(16))             iif ();

    regio_arbiter #(
        .NUM_M   (NM),
        .OFS_W   (8),
        .DAT_W   (16),
        .TMO_CYC (5)
    ) dut (
        .clk40m    (clk40m),
        .reset     (reset),
        .init_lock (init_lock),
        .m         (mif),
        .io        (iif),
        .busy      (busy)
    );

    initial clk40m = 1'b0;
    always #5 clk40m = ~clk40m;

    typedef struct {
        logic        lock;
        logic [2:0]  req;
        int          g;
        logic        wr;
        logic        len;
        logic [7:0]  ofs;
        logic [15:0] wd;
        int          dly;
        logic [15:0] rd;
        logic        err;
        logic [15:0] erd;
    } vec_t;

    vec_t tv[8];

    task automatic tick;
        @(posedge clk40m);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input vec_t v);
        for (int i = 0; i < NM; i++) begin
            if (i == v.g) begin
                mif.m_wr[i]           = v.wr;
                mif.m_len[i]          = v.len;
                mif.m_ofs[i*8 +: 8]   = v.ofs;
                mif.m_wdata[i*16 +: 16] = v.wd;
            end else begin
                mif.m_wr[i]           = ~v.wr;
                mif.m_len[i]          = ~v.len;
                mif.m_ofs[i*8 +: 8]   = ~v.ofs;
                mif.m_wdata[i*16 +: 16] = ~v.wd;
            end
        end
    endtask

    initial begin
        vec_t v;
        int   n;
        logic got;
        logic [2:0] acc;

        tests = 0;
        fails = 0;

        tv[0] = '{1'b1, 3'b111, 0, 1'b1, 1'b1, 8'h20, 16'hA5A5,
                  1, 16'h1111, 1'b0, 16'h1111};
        tv[1] = '{1'b0, 3'b110, 1, 1'b0, 1'b1, 8'h10, 16'h0000,
                  1, 16'h8872, 1'b0, 16'h8872};
        tv[2] = '{1'b0, 3'b110, 2, 1'b1, 1'b0, 8'h44, 16'h00C3,
                  3, 16'h1234, 1'b0, 16'h1234};
        tv[3] = '{1'b0, 3'b011, 0, 1'b0, 1'b1, 8'h08, 16'h5555,
                  0, 16'hDEAD, 1'b1, 16'h1234};
        tv[4] = '{1'b0, 3'b001, 0, 1'b0, 1'b0, 8'h0C, 16'h0101,
                  2, 16'h0F0F, 1'b0, 16'h0F0F};
        tv[5] = '{1'b0, 3'b101, 2, 1'b1, 1'b1, 8'h7E, 16'hCAFE,
                  6, 16'hBEEF, 1'b0, 16'hBEEF};
        tv[6] = '{1'b0, 3'b111, 0, 1'b0, 1'b1, 8'h30, 16'h0002,
                  1, 16'h0001, 1'b0, 16'h0001};
        tv[7] = '{1'b1, 3'b101, 0, 1'b1, 1'b0, 8'h5A, 16'h7777,
                  2, 16'h4242, 1'b0, 16'h4242};

        reset       = 1'b1;
        init_lock   = 1'b0;
        mif.m_req   = '0;
        mif.m_wr    = '0;
        mif.m_len   = '0;
        mif.m_ofs   = '0;
        mif.m_wdata = '0;
        iif.io_done = 1'b0;
        iif.io_rdata = '0;
        #1;
        chk("rst_ack", 32'(mif.m_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_new", 32'(iif.io_new), 0);
        chk("rst_err", 32'(mif.m_err), 0);
        chk("rst_rdata", 32'(mif.m_rdata), 0);
        chk("rst_ofs", 32'(iif.io_ofs), 0);
        tick;
        tick;
        reset = 1'b0;

        // init lock blocks masters 1 and 2
        init_lock = 1'b1;
        mif.m_req = 3'b110;
        got = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (iif.io_new || busy) got = 1'b1;
        end
        chk("lock_block", 32'(got), 0);

        for (int k = 0; k < 8; k++) begin
            v = tv[k];
            init_lock = v.lock;
            set_fields(v);
            mif.m_req = v.req;
            n = 0;
            while (!iif.io_new && n < 10) begin
                tick;
                n++;
            end
            chk($sformatf("v%0d_newlat", k), 32'(n), 1);
            chk($sformatf("v%0d_ofs", k), 32'(iif.io_ofs), 32'(v.ofs));
            chk($sformatf("v%0d_wr", k), 32'(iif.io_wr), 32'(v.wr));
            chk($sformatf("v%0d_len", k), 32'(iif.io_len), 32'(v.len));
            chk($sformatf("v%0d_wd", k), 32'(iif.io_wdata), 32'(v.wd));
            // post-grant input changes must not matter
            mif.m_req   = '0;
            mif.m_ofs   = 24'hFFFFFF;
            mif.m_wdata = '0;
            mif.m_wr    = ~mif.m_wr;
            init_lock   = ~v.lock;
            n = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                iif.io_done  = (v.dly != 0 && n == v.dly);
                iif.io_rdata = v.rd;
                tick;
                n++;
                iif.io_done = 1'b0;
                if (|mif.m_ack) got = 1'b1;
            end
            chk($sformatf("v%0d_acklat", k), 32'(n),
                (v.dly == 0) ? 32'd7 : 32'(v.dly + 1));
            chk($sformatf("v%0d_ack", k), 32'(mif.m_ack), 32'(1 << v.g));
            chk($sformatf("v%0d_err", k), 32'(mif.m_err), 32'(v.err));
            chk($sformatf("v%0d_rdata", k), 32'(mif.m_rdata), 32'(v.erd));
            chk($sformatf("v%0d_hold", k), 32'(iif.io_ofs), 32'(v.ofs));
            tick;
            chk($sformatf("v%0d_ack1", k), 32'(mif.m_ack), 0);
            chk($sformatf("v%0d_idle", k), 32'(busy), 0);
        end

        // io_done while idle is ignored
        init_lock    = 1'b0;
        iif.io_done  = 1'b1;
        iif.io_rdata = 16'hFFFF;
        tick;
        iif.io_done = 1'b0;
        chk("idle_done_busy", 32'(busy), 0);
        chk("idle_done_ack", 32'(mif.m_ack), 0);
        tick;
        chk("idle_done_rdata", 32'(mif.m_rdata), 32'h4242);

        // reset during WAIT aborts with no ack
        mif.m_req = 3'b010;
        n = 0;
        while (!iif.io_new && n < 10) begin
            tick;
            n++;
        end
        chk("mr_newlat", 32'(n), 1);
        mif.m_req = '0;
        tick;
        chk("mr_wait", 32'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_ack", 32'(mif.m_ack), 0);
        chk("mr_rdata", 32'(mif.m_rdata), 0);
        chk("mr_ofs", 32'(iif.io_ofs), 0);
        chk("mr_err", 32'(mif.m_err), 0);
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            tick;
            acc |= mif.m_ack;
        end
        reset = 1'b0;
        tick;
        acc |= mif.m_ack;
        chk("mr_noack", 32'(acc), 0);

        // held requests alternate 0,1,0,1 starting from master 0
        mif.m_ofs = {8'h32, 8'h31, 8'h30};
        mif.m_req = 3'b011;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (!iif.io_new && n < 10) begin
                tick;
                n++;
            end
            chk($sformatf("rr%0d_gap", j), 32'(n), (j == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_ofs", j), 32'(iif.io_ofs),
                32'(8'h30 + 8'(j % 2)));
            tick;
            iif.io_done  = 1'b1;
            iif.io_rdata = 16'(16'h0A00 + j);
            tick;
            iif.io_done = 1'b0;
            if (j == 3) mif.m_req = '0;
            chk($sformatf("rr%0d_ack", j), 32'(mif.m_ack), 32'(1 << (j % 2)));
            chk($sformatf("rr%0d_rd", j), 32'(mif.m_rdata),
                32'(16'h0A00 + j));
        end
        tick;
        chk("rr_end_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regio_arbiter.md
# regio_arbiter

Parametrised N-master arbiter in front of the KSZ8851 register-access engine. It replaces the fixed two-way init/application select with a round-robin arbiter and per-master request/acknowledge handshakes. An init lock keeps master 0 exclusive until initialisation completes. A watchdog stops a hung engine from stalling the bus. It sits between the initialisation sequencer plus application masters and the single register I/O engine.

## Interface
Parameters:
- NUM_M, 2: number of masters, 2..8.
- OFS_W, 8: register offset width.
- DAT_W, 16: data width.
- TMO_CYC, 255: cycles allowed in WAIT before timeout, 1..65535.

Ports:
- clk40m  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- init_lock  in  1  high = only master 0 is eligible.
- m_req  in  NUM_M  per-master request level.
- m_wr  in  NUM_M  1 = write, 0 = read.
- m_len  in  NUM_M  0 = byte, 1 = word.
- m_ofs  in  NUM_M*OFS_W  offsets; master i occupies bits [i*OFS_W +: OFS_W].
- m_wdata  in  NUM_M*DAT_W  write data, packed the same way.
- m_ack  out  NUM_M  one-cycle completion pulse to the owning master.
- m_err  out  1  valid with m_ack; 1 = timeout.
- m_rdata  out  DAT_W  read data, valid with m_ack and held until the next ack.
- io_new  out  1  one-cycle command strobe to the engine.
- io_wr, io_len  out  1 each  captured command fields.
- io_ofs  out  OFS_W  captured offset.
- io_wdata  out  DAT_W  captured write data.
- io_done  in  1  one-cycle completion pulse from the engine.
- io_rdata  in  DAT_W  engine read data, valid with io_done.
- busy  out  1  high in any state except IDLE.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE:** compute the eligible set. It is m_req, masked to bit 0 when init_lock=1. If the set is non-empty:
  - Grant the first eligible master at or after rr_ptr, searching upward and wrapping modulo NUM_M.
  - Capture that master's wr/len/ofs/wdata into the io_* registers.
  - Store the grant index and go to ISSUE.
- **ISSUE:** io_new=1 for exactly one cycle, then go to WAIT and clear the watchdog.
- **WAIT:**
  - On io_done: latch io_rdata into m_rdata, set m_err=0, go to RESP.
  - If the watchdog reaches TMO_CYC first: leave m_rdata unchanged, set m_err=1, go to RESP.
- **RESP:** m_ack[grant]=1 for one cycle. Set rr_ptr to (grant+1) mod NUM_M and return to IDLE.

Rules:
- Captured fields hold from grant until the next grant. Changes on the m_* inputs after grant are ignored.
- A master that drops m_req after grant still gets its command executed and still receives its ack.
- A master must drop or re-present m_req in the cycle after its ack. If m_req is still high in IDLE, it is treated as a new request.
- io_done seen outside WAIT is ignored.
- If io_done and the timeout occur in the same cycle, io_done wins and m_err=0.
- init_lock changing while busy has no effect on the transaction in flight.
- m_ack is one-hot or all zero.

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr=0, watchdog=0.
- Reset asserted mid-transaction aborts immediately and no ack is issued.
- Request high in IDLE at edge k gives io_new high in cycle k+1.
- io_done at edge d gives m_ack in cycle d+1.
- Minimum request-to-ack latency, with io_done arriving one cycle after io_new, is 4 cycles.
- Back-to-back throughput: one command per 4 + engine-latency cycles.
- Watchdog is an unsigned counter 16 bits wide. It saturates and never wraps.
- A timeout produces ack TMO_CYC+2 cycles after io_new.

## Structure
- Package regio_pkg:
  - FSM state enum.
  - Byte/word length constants.
  - Packed-slice helper function for extracting master i's fields.
  - Default TMO_CYC constant.
- One sub-module, rr_pick: combinational round-robin first-one search from a rotating pointer over NUM_M bits. Outputs are index and found.

## Test plan
- **Init lock:** NUM_M=3, init_lock=1, m_req=3'b110 → no io_new. Raise m_req[0] → master 0 is granted. Drop init_lock → masters 1 then 2 are served in order.
- **Round robin:** m_req=2'b11 held continuously → grants alternate 0,1,0,1. Each ack appears 4 cycles after its command's request when io_done comes one cycle after io_new.
- **Read:** master 1 reads ofs=8'h10, len=1; the engine returns 16'h8872 → m_rdata=16'h8872, m_ack=2'b10, m_err=0.
- **Timeout:** TMO_CYC=5 and io_done is never asserted → m_ack with m_err=1 seven cycles after io_new. The next request is then served normally.
- **Simultaneous events:** io_done coincides with the timeout → m_err=0. io_done pulsed in IDLE → ignored.
- **Mid-transaction reset:** reset asserted in WAIT → all outputs 0 asynchronously with no ack. After release, rr_ptr=0 and master 0 is granted first.
